// File: rtl/booth_datapath.sv
// rtl/booth_datapath.sv - Booth radix-2 signed multiplier datapath
//
// Holds M (multiplicand), HQ (WIDTH+1-bit accumulator), LQ (multiplier), Q_1 and the
// step counter. The external Booth control FSM drives it through load_A, load_B,
// load_add, add_sub and shift_HQ_LQ_Q_1. {Q_LSQ_0, Q_LSQ_1} is returned to the FSM
// as the recode pair.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   load_A / multiplicand     capture M
//   load_B / multiplier       capture LQ, clear HQ/Q_1/done, cnt <= WIDTH
//   load_add, add_sub         HQ <= HQ + M (add_sub=0) or HQ - M (add_sub=1)
//   shift_HQ_LQ_Q_1           arithmetic shift right of {HQ,LQ,Q_1}, cnt decrements
//   Q_LSQ_0, Q_LSQ_1          LQ[0] and Q_1
//   product, done             {HQ[WIDTH-1:0], LQ}, valid while done=1
//   err                       sticky protocol error
//
// Build option: BOOTH_SHIFT_GUARD_EN - when defined, load_add/shift at cnt==0 are
// ignored and raise err; when undefined they execute and err is tied low.

module booth_datapath #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_A,
    input  logic               load_B,
    input  logic               load_add,
    input  logic               add_sub,
    input  logic               shift_HQ_LQ_Q_1,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               Q_LSQ_0,
    output logic               Q_LSQ_1,
    output logic [2*WIDTH-1:0] product,
    output logic               done,
    output logic               err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] m_q,    m_d;
    logic [WIDTH:0]   hq_q,   hq_d;
    logic [WIDTH-1:0] lq_q,   lq_d;
    logic             q1_q,   q1_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             done_q, done_d;
    logic             err_q,  err_d;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   hq_pre;
    logic             idle;
    logic             cmd_en;

    always_comb begin
        m_d    = load_A ? multiplicand : m_q;
        // Sign extension into the extra HQ bit keeps M = -2^(WIDTH-1) exact.
        m_ext  = {m_q[WIDTH-1], m_q};
        sum    = add_sub ? (hq_q - m_ext) : (hq_q + m_ext);
        idle   = (cnt_q == '0);

`ifdef BOOTH_SHIFT_GUARD_EN
        cmd_en = !idle;
        // load_B wins over load_add/shift, so those are not errors when it is present.
        err_d  = err_q | (!load_B && (load_add || shift_HQ_LQ_Q_1) && idle);
`else
        cmd_en = 1'b1;
        err_d  = 1'b0;
`endif

        hq_d   = hq_q;
        lq_d   = lq_q;
        q1_d   = q1_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        hq_pre = hq_q;

        if (load_B) begin
            hq_d   = '0;
            lq_d   = multiplier;
            q1_d   = 1'b0;
            cnt_d  = CNT_W'(WIDTH);
            done_d = 1'b0;
        end else begin
            // Add result feeds the shifter directly, fusing add+shift into one edge.
            if (load_add && cmd_en) begin
                hq_pre = sum;
            end
            hq_d = hq_pre;
            if (shift_HQ_LQ_Q_1 && cmd_en) begin
                hq_d = {hq_pre[WIDTH], hq_pre[WIDTH:1]};
                lq_d = {hq_pre[0], lq_q[WIDTH-1:1]};
                q1_d = lq_q[0];
                if (!idle) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q == CNT_W'(1)) begin
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= '0;
            hq_q   <= '0;
            lq_q   <= '0;
            q1_q   <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            m_q    <= m_d;
            hq_q   <= hq_d;
            lq_q   <= lq_d;
            q1_q   <= q1_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign Q_LSQ_0 = lq_q[0];
    assign Q_LSQ_1 = q1_q;
    assign product = {hq_q[WIDTH-1:0], lq_q};
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_booth_datapath.sv
// tb/tb_booth_datapath.sv - scoreboard bench for booth_datapath (WIDTH=8)

module tb_booth_datapath;

    logic        clk;
    logic        rst;
    logic        load_A;
    logic        load_B;
    logic        load_add;
    logic        add_sub;
    logic        shift_HQ_LQ_Q_1;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        Q_LSQ_0;
    logic        Q_LSQ_1;
    logic [15:0] product;
    logic        done;
    logic        err;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_q[$];
    logic        done_prev;

    booth_datapath #(.WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .load_A          (load_A),
        .load_B          (load_B),
        .load_add        (load_add),
        .add_sub         (add_sub),
        .shift_HQ_LQ_Q_1 (shift_HQ_LQ_Q_1),
        .multiplicand    (multiplicand),
        .multiplier      (multiplier),
        .Q_LSQ_0         (Q_LSQ_0),
        .Q_LSQ_1         (Q_LSQ_1),
        .product         (product),
        .done            (done),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising edge of done presents a product to the scoreboard.
    initial done_prev = 1'b0;
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got product %h with empty scoreboard", product);
            end else begin
                check("product", product, exp_q.pop_front());
            end
        end
        done_prev = done;
    end

    task automatic clear_cmds();
        load_A = 1'b0; load_B = 1'b0; load_add = 1'b0; add_sub = 1'b0; shift_HQ_LQ_Q_1 = 1'b0;
    endtask

    // Drive one command cycle: inputs set at negedge, act on posedge, cleared after.
    task automatic cmd(input logic la, input logic lb, input logic ladd, input logic asub, input logic sh);
        @(negedge clk);
        load_A = la; load_B = lb; load_add = ladd; add_sub = asub; shift_HQ_LQ_Q_1 = sh;
        @(posedge clk);
        #1;
        clear_cmds();
    endtask

    task automatic start(input logic [7:0] a, input logic [7:0] b);
        multiplicand = a;
        multiplier   = b;
        cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // One Booth step as the control FSM would issue it, from the recode pair.
    task automatic step(input bit fused);
        logic [1:0] pr;
        pr = {Q_LSQ_0, Q_LSQ_1};
        if (pr == 2'b01 || pr == 2'b10) begin
            if (fused) begin
                cmd(1'b0, 1'b0, 1'b1, pr[1], 1'b1);
            end else begin
                cmd(1'b0, 1'b0, 1'b1, pr[1], 1'b0);
                cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end else begin
            cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic steps(input int n, input bit fused);
        for (int i = 0; i < n; i++) step(fused);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        multiplicand = '0;
        multiplier = '0;
        clear_cmds();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset_product", product, 16'h0000);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_err", {15'd0, err}, 16'd0);
        check("reset_recode", {14'd0, Q_LSQ_0, Q_LSQ_1}, 16'd0);

        // 3 * -4, separate add and shift cycles
        exp_q.push_back(16'hFFF4);
        start(8'd3, 8'hFC);
        steps(8, 1'b0);

        // -128 * -128
        exp_q.push_back(16'h4000);
        start(8'h80, 8'h80);
        steps(8, 1'b0);

        // 7 * 5 with fused add+shift; done must rise on the 8th shift edge
        exp_q.push_back(16'h0023);
        start(8'd7, 8'd5);
        steps(7, 1'b1);
        check("done_before_8th", {15'd0, done}, 16'd0);
        steps(1, 1'b1);
        check("done_after_8th", {15'd0, done}, 16'd1);

        // Asynchronous reset in the middle of step 4
        start(8'd7, 8'd5);
        steps(3, 1'b0);
        @(negedge clk);
        shift_HQ_LQ_Q_1 = 1'b1;
        #2 rst = 1'b1;
        clear_cmds();
        #1;
        check("async_rst_product", product, 16'h0000);
        check("async_rst_flags", {13'd0, done, err, Q_LSQ_0}, 16'd0);
        check("async_rst_q1", {15'd0, Q_LSQ_1}, 16'd0);
        #1 rst = 1'b0;

        // Fresh run after reset: -5 * 6
        exp_q.push_back(16'hFFE2);
        start(8'hFB, 8'd6);
        steps(8, 1'b1);

        // load_B together with load_add and shift mid-run
        start(8'd3, 8'hFC);
        steps(3, 1'b0);
        multiplier = 8'h5A;
        cmd(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("midrun_loadB_product", product, 16'h005A);
        check("midrun_loadB_flags", {14'd0, done, Q_LSQ_1}, 16'd0);
        // Counter reloaded to 8: finish with 3 * 90
        exp_q.push_back(16'h010E);
        steps(7, 1'b0);
        check("reload_not_done_7", {15'd0, done}, 16'd0);
        steps(1, 1'b0);
        check("reload_done_8", {15'd0, done}, 16'd1);

        // Extra shift after done
        cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef BOOTH_SHIFT_GUARD_EN
        check("guard_product_held", product, 16'h010E);
        check("guard_err_set", {15'd0, err}, 16'd1);
`else
        check("noguard_product_shifted", product, 16'h0087);
        check("noguard_err_low", {15'd0, err}, 16'd0);
`endif
        check("extra_shift_done_held", {15'd0, done}, 16'd1);

        // Final run also checks err across load_B
        exp_q.push_back(16'hC080);
        start(8'h80, 8'd127);
`ifdef BOOTH_SHIFT_GUARD_EN
        check("guard_err_sticky", {15'd0, err}, 16'd1);
`else
        check("noguard_err_stays", {15'd0, err}, 16'd0);
`endif
        check("loadB_clears_done", {15'd0, done}, 16'd0);
        steps(8, 1'b1);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
